// File: rtl/drive_mode_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : drive_mode_scheduler_pkg                                    |
// | Brief   : Shared drivetrain types: scheduler state encoding, grant    |
// |           sentinel and motor command bundle field offsets.            |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package drive_mode_scheduler_pkg;

   localparam int NUM_REQ = 3;
   localparam int CMD_W   = 8;

   // Motor command bundle: {FWDA,FWDB,BWDA,BWDB,DutyCycleA[1:0],DutyCycleB[1:0]}
   localparam int CMD_FWDA    = 7;
   localparam int CMD_FWDB    = 6;
   localparam int CMD_BWDA    = 5;
   localparam int CMD_BWDB    = 4;
   localparam int CMD_DCA_LSB = 2;
   localparam int CMD_DCB_LSB = 0;

   localparam logic [1:0] GRANT_NONE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_RUN      = 3'd2,
      ST_DEADTIME = 3'd3,
      ST_HALT     = 3'd4
   } state_t;

   // Lowest set index wins; GRANT_NONE when nothing is requested.
   function automatic logic [1:0] pick_lowest(input logic [NUM_REQ-1:0] req);
      logic [1:0] idx;
      idx = GRANT_NONE;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // One-hot of a requester index; out-of-range index yields all zeros.
   function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (idx == 2'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/drive_cmd_mux.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : drive_cmd_mux                                               |
// | Brief   : Registered 3:1 motor command bundle mux with force-zero.    |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module drive_cmd_mux
   import drive_mode_scheduler_pkg::*;
(
   input  logic                     clk,
   input  logic                     Reset_n,
   input  logic [NUM_REQ*CMD_W-1:0] cmd_i,
   input  logic [1:0]               sel_i,
   input  logic                     force_zero_i,
   output logic [CMD_W-1:0]         cmd_o
);

   logic [CMD_W-1:0] cmd_d;
   logic [CMD_W-1:0] cmd_q;

   // Select the granted bundle, or drive zero when forced / nothing selected.
   always_comb begin
      cmd_d = '0;
      if (!force_zero_i) begin
         case (sel_i)
            2'd0:    cmd_d = cmd_i[0*CMD_W +: CMD_W];
            2'd1:    cmd_d = cmd_i[1*CMD_W +: CMD_W];
            2'd2:    cmd_d = cmd_i[2*CMD_W +: CMD_W];
            default: cmd_d = '0;
         endcase
      end
   end

   // Output register; async clear keeps the bridge de-energised in reset.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) cmd_q <= '0;
      else          cmd_q <= cmd_d;
   end

   assign cmd_o = cmd_q;

endmodule
`default_nettype wire

// File: rtl/drive_mode_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : drive_mode_scheduler                                        |
// | Brief   : Fixed-priority Enable/Done scheduler sharing the motor      |
// |           command outputs between three direction controllers, with  |
// |           handover dead-time, start/run timeouts and emergency stop.  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module drive_mode_scheduler
   import drive_mode_scheduler_pkg::*;
#(
   parameter int unsigned START_TIMEOUT = 4,
   parameter int unsigned RUN_TIMEOUT   = 5_000_000,
   parameter int unsigned DEADTIME      = 8,
   parameter int unsigned CNT_W         = 24
) (
   input  logic                     clk,
   input  logic                     Reset_n,
   input  logic [NUM_REQ-1:0]       Req,
   input  logic [NUM_REQ-1:0]       DoneIn,
   input  logic [NUM_REQ*CMD_W-1:0] CmdIn,
   input  logic                     Pause,
   input  logic                     Estop,
   output logic [NUM_REQ-1:0]       Enable,
   output logic [NUM_REQ-1:0]       PauseOut,
   output logic                     FWDA,
   output logic                     FWDB,
   output logic                     BWDA,
   output logic                     BWDB,
   output logic [1:0]               DutyCycleA,
   output logic [1:0]               DutyCycleB,
   output logic [1:0]               Grant,
   output logic                     Busy,
   output logic                     Fault
);

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DT_LAST    = CNT_W'(DEADTIME - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     cnt_inc;
   logic [1:0]           g_q, g_d;
   logic [1:0]           grant_q, grant_d;
   logic [NUM_REQ-1:0]   enable_q, enable_d;
   logic [NUM_REQ-1:0]   pause_q, pause_d;
   logic                 fault_q, fault_d;
   logic                 busy_q;
   logic [NUM_REQ:0]     done_ext;
   logic                 done_g;
   logic                 motor_zero;
   logic [CMD_W-1:0]     cmd;

   // Saturating increment so a stuck state can never wrap into a false match.
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   // Extra '1' entry lets the GRANT_NONE index read as an idle requester.
   assign done_ext = {1'b1, DoneIn};
   assign done_g   = done_ext[g_q];

   // Next-state, counter and registered-output logic; Estop overrides all.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      g_d      = g_q;
      grant_d  = grant_q;
      enable_d = '0;
      pause_d  = pause_q;
      fault_d  = fault_q;

      if (Estop) begin
         state_d = ST_HALT;
         cnt_d   = '0;
         pause_d = '1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|Req) begin
                  g_d      = pick_lowest(Req);
                  grant_d  = pick_lowest(Req);
                  enable_d = idx_onehot(pick_lowest(Req));
                  fault_d  = 1'b0;
                  cnt_d    = '0;
                  state_d  = ST_START;
               end
            end
            ST_START: begin
               enable_d = idx_onehot(g_q);
               cnt_d    = cnt_inc;
               if (!done_g) begin
                  enable_d = '0;
                  cnt_d    = '0;
                  state_d  = ST_RUN;
               end else if (cnt_q == START_LAST) begin
                  enable_d = '0;
                  fault_d  = 1'b1;
                  cnt_d    = '0;
                  state_d  = ST_DEADTIME;
               end
            end
            ST_RUN: begin
               pause_d = Pause ? idx_onehot(g_q) : '0;
               if (!Pause) cnt_d = cnt_inc;
               // Completion wins over a coincident timeout.
               if (done_g) begin
                  cnt_d   = '0;
                  state_d = ST_DEADTIME;
               end else if (!Pause && (cnt_q == RUN_LAST)) begin
                  fault_d = 1'b1;
                  pause_d = idx_onehot(g_q);
                  cnt_d   = '0;
                  state_d = ST_DEADTIME;
               end
            end
            ST_DEADTIME: begin
               cnt_d = cnt_inc;
               if (cnt_q == DT_LAST) begin
                  grant_d = GRANT_NONE;
                  pause_d = '0;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end
            ST_HALT: begin
               pause_d = '1;
               cnt_d   = '0;
               state_d = ST_DEADTIME;
            end
            default: begin
               state_d = ST_IDLE;
               grant_d = GRANT_NONE;
               pause_d = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State, counter and control-output registers.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         g_q      <= GRANT_NONE;
         grant_q  <= GRANT_NONE;
         enable_q <= '0;
         pause_q  <= '0;
         fault_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         g_q      <= g_d;
         grant_q  <= grant_d;
         enable_q <= enable_d;
         pause_q  <= pause_d;
         fault_q  <= fault_d;
         busy_q   <= (state_d != ST_IDLE);
      end
   end

   // Motors load only on a RUN->RUN edge: one cycle of latency after RUN
   // entry, and zero on the very edge that leaves RUN.
   assign motor_zero = (state_q != ST_RUN) || (state_d != ST_RUN);

   drive_cmd_mux u_cmd_mux (
      .clk          (clk),
      .Reset_n      (Reset_n),
      .cmd_i        (CmdIn),
      .sel_i        (g_q),
      .force_zero_i (motor_zero),
      .cmd_o        (cmd)
   );

   assign FWDA       = cmd[CMD_FWDA];
   assign FWDB       = cmd[CMD_FWDB];
   assign BWDA       = cmd[CMD_BWDA];
   assign BWDB       = cmd[CMD_BWDB];
   assign DutyCycleA = cmd[CMD_DCA_LSB +: 2];
   assign DutyCycleB = cmd[CMD_DCB_LSB +: 2];
   assign Enable     = enable_q;
   assign PauseOut   = pause_q;
   assign Grant      = grant_q;
   assign Busy       = busy_q;
   assign Fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_drive_mode_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_drive_mode_scheduler                                     |
// | Brief   : Directed bench with cycle-tagged expectation scoreboard.    |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_drive_mode_scheduler;

   localparam int S_GNT = 0;
   localparam int S_EN  = 1;
   localparam int S_MOT = 2;
   localparam int S_PAU = 3;
   localparam int S_FLT = 4;
   localparam int S_BSY = 5;

   logic        clk = 1'b0;
   logic        Reset_n;
   logic [2:0]  Req;
   logic [2:0]  DoneIn;
   logic [23:0] CmdIn;
   logic        Pause;
   logic        Estop;
   logic [2:0]  Enable;
   logic [2:0]  PauseOut;
   logic        FWDA, FWDB, BWDA, BWDB;
   logic [1:0]  DutyCycleA, DutyCycleB;
   logic [1:0]  Grant;
   logic        Busy;
   logic        Fault;

   typedef struct {
      string      nm;
      int         cyc;
      int         sel;
      logic [7:0] exp;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   drive_mode_scheduler #(
      .START_TIMEOUT (4),
      .RUN_TIMEOUT   (50),
      .DEADTIME      (8),
      .CNT_W         (24)
   ) dut (
      .clk        (clk),
      .Reset_n    (Reset_n),
      .Req        (Req),
      .DoneIn     (DoneIn),
      .CmdIn      (CmdIn),
      .Pause      (Pause),
      .Estop      (Estop),
      .Enable     (Enable),
      .PauseOut   (PauseOut),
      .FWDA       (FWDA),
      .FWDB       (FWDB),
      .BWDA       (BWDA),
      .BWDB       (BWDB),
      .DutyCycleA (DutyCycleA),
      .DutyCycleB (DutyCycleB),
      .Grant      (Grant),
      .Busy       (Busy),
      .Fault      (Fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] cur(input int sel);
      case (sel)
         S_GNT:   return {6'b0, Grant};
         S_EN:    return {5'b0, Enable};
         S_MOT:   return {FWDA, FWDB, BWDA, BWDB, DutyCycleA, DutyCycleB};
         S_PAU:   return {5'b0, PauseOut};
         S_FLT:   return {7'b0, Fault};
         default: return {7'b0, Busy};
      endcase
   endfunction

   // Expect value v on signal sel at the negedge after k more rising edges.
   task automatic chk(input string nm, input int sel, input int k, input logic [7:0] v);
      exp_t e;
      e.nm  = nm;
      e.cyc = cyc + k;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every expectation that falls due at this negedge.
   always @(negedge clk) begin
      logic [7:0] got;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            n_cmp = n_cmp + 1;
            got = cur(sb[i].sel);
            if (sb[i].cyc < cyc || got !== sb[i].exp) begin
               n_bad = n_bad + 1;
               $display("FAIL %s (cycle %0d): got %0h, expected %0h", sb[i].nm, sb[i].cyc, got, sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0;
      Req     = 3'b000;
      DoneIn  = 3'b111;
      CmdIn   = {8'h35, 8'hCA, 8'h5F};
      Pause   = 1'b0;
      Estop   = 1'b0;
      step(2);
      n_cmp = n_cmp + 1;
      if (Grant !== 2'b11 || Enable !== 3'b000 || PauseOut !== 3'b000) begin
         n_bad = n_bad + 1;
         $display("FAIL rst_direct_ctrl: Grant=%0h Enable=%0h PauseOut=%0h", Grant, Enable, PauseOut);
      end
      n_cmp = n_cmp + 1;
      if ({FWDA, FWDB, BWDA, BWDB, DutyCycleA, DutyCycleB} !== 8'h00 || Busy !== 1'b0 || Fault !== 1'b0) begin
         n_bad = n_bad + 1;
         $display("FAIL rst_direct_mot: motors/busy/fault not at reset values");
      end
      chk("rst_grant", S_GNT, 0, 8'h3);
      chk("rst_en",    S_EN,  0, 8'h0);
      chk("rst_mot",   S_MOT, 0, 8'h0);
      chk("rst_pause", S_PAU, 0, 8'h0);
      chk("rst_fault", S_FLT, 0, 8'h0);
      chk("rst_busy",  S_BSY, 0, 8'h0);
      step(1);
      Reset_n = 1'b1;
      step(2);

      // Requester 1 wins over 2, runs command 0xCA, then completes.
      Req = 3'b110;
      chk("t1_grant", S_GNT, 1, 8'h1);
      chk("t1_en",    S_EN,  1, 8'h2);
      chk("t1_busy",  S_BSY, 1, 8'h1);
      step(2);
      DoneIn = 3'b101;
      Req    = 3'b000;
      chk("t1_en_drop", S_EN,  1, 8'h0);
      chk("t1_mot_lat", S_MOT, 1, 8'h0);
      chk("t1_mot",     S_MOT, 2, 8'hCA);
      chk("t1_pause",   S_PAU, 2, 8'h0);
      step(4);
      chk("t1_mot_hold", S_MOT, 0, 8'hCA);
      DoneIn = 3'b111;
      chk("t1_mot_off",    S_MOT, 1, 8'h0);
      chk("t1_grant_dt",   S_GNT, 8, 8'h1);
      chk("t1_grant_idle", S_GNT, 9, 8'h3);
      chk("t1_busy_idle",  S_BSY, 9, 8'h0);
      step(11);

      // Requester 0 before 2; dead-time with zero motors in between.
      Req = 3'b101;
      chk("t2_grant0", S_GNT, 1, 8'h0);
      chk("t2_en0",    S_EN,  1, 8'h1);
      step(1);
      DoneIn = 3'b110;
      chk("t2_mot0", S_MOT, 2, 8'h5F);
      step(2);
      chk("t2_mot0_hold", S_MOT, 0, 8'h5F);
      DoneIn = 3'b111;
      Req    = 3'b100;
      for (int k = 1; k <= 10; k++) chk("t2_gap_mot", S_MOT, k, 8'h0);
      chk("t2_gap_grant", S_GNT, 9,  8'h3);
      chk("t2_gap_en",    S_EN,  9,  8'h0);
      chk("t2_grant2",    S_GNT, 10, 8'h2);
      chk("t2_en2",       S_EN,  10, 8'h4);
      step(10);
      DoneIn = 3'b011;
      Req    = 3'b000;
      chk("t2_mot2", S_MOT, 2, 8'h35);
      step(2);
      chk("t2_mot2_hold", S_MOT, 0, 8'h35);
      DoneIn = 3'b111;
      chk("t2_mot2_off", S_MOT, 1, 8'h0);
      step(10);

      // Start timeout: granted Done never falls.
      Req = 3'b001;
      chk("t3_en",     S_EN,  1, 8'h1);
      chk("t3_fault0", S_FLT, 1, 8'h0);
      step(1);
      Req = 3'b000;
      chk("t3_fault_pre", S_FLT, 3,  8'h0);
      chk("t3_en_pre",    S_EN,  3,  8'h1);
      chk("t3_mot",       S_MOT, 2,  8'h0);
      chk("t3_fault",     S_FLT, 4,  8'h1);
      chk("t3_en_drop",   S_EN,  4,  8'h0);
      chk("t3_mot_to",    S_MOT, 4,  8'h0);
      chk("t3_busy",      S_BSY, 4,  8'h1);
      chk("t3_fault_st",  S_FLT, 12, 8'h1);
      chk("t3_grant_idle",S_GNT, 12, 8'h3);
      step(13);

      // Fault clears on next grant; pause freezes the run timeout.
      Req = 3'b010;
      chk("t4_fault_clr", S_FLT, 1, 8'h0);
      chk("t4_grant",     S_GNT, 1, 8'h1);
      step(1);
      DoneIn = 3'b101;
      Req    = 3'b000;
      step(1);
      Pause = 1'b1;
      chk("t4_pause",      S_PAU, 1,   8'h2);
      chk("t4_pause_end",  S_PAU, 100, 8'h2);
      chk("t4_no_to",      S_FLT, 100, 8'h0);
      chk("t4_unpause",    S_PAU, 101, 8'h0);
      chk("t4_pre_to",     S_FLT, 149, 8'h0);
      chk("t4_pre_to_mot", S_MOT, 149, 8'hCA);
      chk("t4_to",         S_FLT, 150, 8'h1);
      chk("t4_to_pause",   S_PAU, 150, 8'h2);
      chk("t4_to_mot",     S_MOT, 150, 8'h0);
      chk("t4_dt_pause",   S_PAU, 157, 8'h2);
      chk("t4_idle_pause", S_PAU, 158, 8'h0);
      chk("t4_idle_grant", S_GNT, 158, 8'h3);
      step(100);
      Pause = 1'b0;
      step(60);
      DoneIn = 3'b111;
      step(2);

      // Emergency stop mid-RUN.
      Req = 3'b100;
      step(1);
      DoneIn = 3'b011;
      Req    = 3'b000;
      step(3);
      chk("t5_mot_run", S_MOT, 0, 8'h35);
      Estop = 1'b1;
      chk("t5_mot",   S_MOT, 1, 8'h0);
      chk("t5_pause", S_PAU, 1, 8'h7);
      chk("t5_en",    S_EN,  1, 8'h0);
      chk("t5_grant", S_GNT, 1, 8'h2);
      chk("t5_busy",  S_BSY, 1, 8'h1);
      step(1);
      Estop  = 1'b0;
      DoneIn = 3'b111;
      chk("t5_dt_pause",   S_PAU, 1, 8'h7);
      chk("t5_dt_grant",   S_GNT, 8, 8'h2);
      chk("t5_dt_busy",    S_BSY, 8, 8'h1);
      chk("t5_idle_grant", S_GNT, 9, 8'h3);
      chk("t5_idle_pause", S_PAU, 9, 8'h0);
      chk("t5_idle_busy",  S_BSY, 9, 8'h0);
      step(10);

      // Req and Estop together in IDLE: halt without a grant.
      Req   = 3'b001;
      Estop = 1'b1;
      chk("t6_grant", S_GNT, 1, 8'h3);
      chk("t6_en",    S_EN,  1, 8'h0);
      chk("t6_pause", S_PAU, 1, 8'h7);
      chk("t6_busy",  S_BSY, 1, 8'h1);
      step(1);
      Req   = 3'b000;
      Estop = 1'b0;
      step(11);

      // Asynchronous reset mid-RUN with a live pause.
      Req = 3'b001;
      step(1);
      DoneIn = 3'b110;
      Req    = 3'b000;
      step(1);
      Pause = 1'b1;
      step(2);
      chk("t7_mot_run",   S_MOT, 0, 8'h5F);
      chk("t7_pause_run", S_PAU, 0, 8'h1);
      step(1);
      Reset_n = 1'b0;
      #1;
      n_cmp = n_cmp + 1;
      if (Grant !== 2'b11 || PauseOut !== 3'b000 || Busy !== 1'b0 ||
          {FWDA, FWDB, BWDA, BWDB, DutyCycleA, DutyCycleB} !== 8'h00) begin
         n_bad = n_bad + 1;
         $display("FAIL t7_async_direct: outputs not cleared without a clock edge");
      end
      chk("t7_grant", S_GNT, 0, 8'h3);
      chk("t7_en",    S_EN,  0, 8'h0);
      chk("t7_mot",   S_MOT, 0, 8'h0);
      chk("t7_pause", S_PAU, 0, 8'h0);
      chk("t7_fault", S_FLT, 0, 8'h0);
      chk("t7_busy",  S_BSY, 0, 8'h0);
      step(2);
      Reset_n = 1'b1;
      Pause   = 1'b0;
      DoneIn  = 3'b111;
      chk("t7_post_grant", S_GNT, 2, 8'h3);
      step(4);
      n_cmp = n_cmp + 1;
      if (Grant !== 2'b11 || Enable !== 3'b000 || Busy !== 1'b0) begin
         n_bad = n_bad + 1;
         $display("FAIL t7_post_direct: grant issued without a fresh Req");
      end

      foreach (sb[i]) begin
         n_bad = n_bad + 1;
         $display("FAIL %s (cycle %0d): never compared, expected %0h", sb[i].nm, sb[i].cyc, sb[i].exp);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      if (n_bad != 0) $display("*** TEST FAILED ***");
      else            $display("*** TEST PASSED ***");
      $finish;
   end

endmodule
`default_nettype wire
